// File: rtl/core_defs.sv
// Shared pipeline definitions: controller state encoding, the hard-wired zero
// register and the NOP written into flushed pipeline registers.
package core_defs;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard comparator: flags an ID instruction that needs the result of
// a load still sitting in EX.
module hazard_detect
  import core_defs::*;
(
  input  logic [4:0] id_rs1_addr_i,
  input  logic [4:0] id_rs2_addr_i,
  input  logic       id_rs1_ren_i,
  input  logic       id_rs2_ren_i,
  input  logic [4:0] ex_rd_addr_i,
  input  logic       ex_reg_wen_i,
  input  logic       ex_is_load_i,
  output logic       load_use_o
);

  logic rs1_hit;
  logic rs2_hit;
  logic ex_load_writes;

  // x0 is never written, so a load targeting it can never create a dependency.
  assign ex_load_writes = ex_is_load_i & ex_reg_wen_i & (ex_rd_addr_i != REG_ZERO);
  assign rs1_hit        = id_rs1_ren_i & (id_rs1_addr_i == ex_rd_addr_i);
  assign rs2_hit        = id_rs2_ren_i & (id_rs2_addr_i == ex_rd_addr_i);
  assign load_use_o     = ex_load_writes & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Hazard and sequencing controller for the five-stage core: arbitrates jumps,
// multi-cycle holds, load-use bubbles and fetch-bus waits into stall/flush/redirect.
module pipe_ctrl
  import core_defs::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned BUS_TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_req_i,
  input  logic        bus_wait_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic        id_rs1_ren_i,
  input  logic        id_rs2_ren_i,
  input  logic [4:0]  ex_rd_addr_i,
  input  logic        ex_reg_wen_i,
  input  logic        ex_is_load_i,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        stall_id_ex_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        bus_err_o,
  output logic [1:0]  state_o
);

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [7:0] WAIT_LAST  = 8'(BUS_TIMEOUT - 1);
  localparam logic [7:0] WAIT_SAT   = 8'hFF;

  state_e     state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;

  logic load_use;
  logic hold_active;
  logic stall_pc, stall_if_id, stall_id_ex;
  logic flush_if_id, flush_id_ex;
  logic jump_take, bus_err;

  hazard_detect u_hazard_detect (
    .id_rs1_addr_i (id_rs1_addr_i),
    .id_rs2_addr_i (id_rs2_addr_i),
    .id_rs1_ren_i  (id_rs1_ren_i),
    .id_rs2_ren_i  (id_rs2_ren_i),
    .ex_rd_addr_i  (ex_rd_addr_i),
    .ex_reg_wen_i  (ex_reg_wen_i),
    .ex_is_load_i  (ex_is_load_i),
    .load_use_o    (load_use)
  );

  // An ongoing hold masks jumps; once hold_req_i drops the cycle behaves as RUN.
  assign hold_active = (state_q == ST_HOLD) && hold_req_i;

  always_comb begin
    // NOTE: every signal gets a default before the priority chain, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    wait_cnt_d  = '0;
    stall_pc    = 1'b0;
    stall_if_id = 1'b0;
    stall_id_ex = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    jump_take   = 1'b0;
    bus_err     = 1'b0;

    if (jump_en_i && !hold_active) begin
      jump_take   = 1'b1;
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d     = ST_FLUSH;
        flush_cnt_d = FLUSH_LOAD;
      end else begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end
    end else if (state_q == ST_FLUSH) begin
      flush_if_id = 1'b1;
      flush_id_ex = 1'b1;
      if (flush_cnt_q <= 2'd1) begin
        state_d     = ST_RUN;
        flush_cnt_d = '0;
      end else begin
        flush_cnt_d = flush_cnt_q - 2'd1;
      end
    end else if (hold_req_i) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      stall_id_ex = 1'b1;
      state_d     = ST_HOLD;
    end else if (load_use && (state_q != ST_WAIT)) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      flush_id_ex = 1'b1;
      state_d     = ST_RUN;
    end else if (bus_wait_i) begin
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
      state_d     = ST_WAIT;
      if (wait_cnt_q == WAIT_LAST) begin
        bus_err    = 1'b1;
        wait_cnt_d = '0;
      end else if (wait_cnt_q != WAIT_SAT) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end else begin
        wait_cnt_d = wait_cnt_q;
      end
    end else begin
      state_d = ST_RUN;
    end
  end

  // Outputs are gated by rst so they drop the instant reset asserts; a flush
  // always overrides a stall on the same pipeline register.
  assign stall_pc_o    = rst & stall_pc;
  assign stall_if_id_o = rst & stall_if_id & ~flush_if_id;
  assign stall_id_ex_o = rst & stall_id_ex & ~flush_id_ex;
  assign flush_if_id_o = rst & flush_if_id;
  assign flush_id_ex_o = rst & flush_id_ex;
  assign jump_en_o     = rst & jump_take;
  assign jump_addr_o   = (rst & jump_take) ? jump_addr_i : '0;
  assign bus_err_o     = rst & bus_err;
  assign state_o       = state_q;

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments make every register sample the pre-edge
    // value of the others, which is what a flip-flop does.
    if (!rst) begin
      state_q     <= ST_RUN;
      flush_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

endmodule
